// File: rtl/router_pkg.sv
// Shared types and header field layout for the router ingress slice.
package router_pkg;

   localparam int unsigned DW           = 8;
   localparam int unsigned HDR_ADDR_LSB = 0;
   localparam int unsigned HDR_ADDR_MSB = 1;
   localparam int unsigned HDR_LEN_LSB  = 2;
   localparam int unsigned HDR_LEN_MSB  = 7;
   localparam int unsigned ADDR_W       = HDR_ADDR_MSB - HDR_ADDR_LSB + 1;
   localparam int unsigned LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;

   typedef enum logic [2:0] {
      IDLE,
      PAYLOAD,
      PARITY,
      FLUSH,
      DROP
   } state_t;

   function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DW-1:0] hdr);
      return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
   endfunction

   function automatic logic [LEN_W-1:0] hdr_len(input logic [DW-1:0] hdr);
      return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
   endfunction

endpackage

// File: rtl/router_ingress_fsm.sv
// Packet framing state machine: tracks header/payload/parity position and
// the remaining payload count; pulses parity_done when a packet completes.
module router_ingress_fsm
   import router_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 3
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          accept,
   input  logic [DW-1:0] data_in,
   input  logic          wr_any,
   output state_t        state,
   output logic          parity_done
);

   logic [LEN_W-1:0] rem;
   logic [LEN_W-1:0] len;
   logic             dest_ok;

   always_comb begin
      len     = hdr_len(data_in);
      dest_ok = 32'(hdr_addr(data_in)) < NUM_PORTS;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         rem         <= '0;
         parity_done <= 1'b0;
      end else begin
         parity_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  rem <= len;
                  if (!dest_ok)
                     state <= DROP;
                  else if (len == '0)
                     state <= PARITY;
                  else
                     state <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (accept) begin
                  if (rem != '0)
                     rem <= rem - 1'b1;
                  if (rem <= LEN_W'(1))
                     state <= PARITY;
               end
            end
            PARITY: begin
               if (accept)
                  state <= FLUSH;
            end
            FLUSH: begin
               if (wr_any) begin
                  parity_done <= 1'b1;
                  state       <= IDLE;
               end
            end
            DROP: begin
               // rem counts payload bytes still to drop; rem==0 means this is the parity byte
               if (accept) begin
                  if (rem == '0) begin
                     parity_done <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     rem <= rem - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/router_ingress.sv
// Router ingress: hold register, FIFO write steering, source stall and
// packet parity check in front of the per-port router FIFOs.
module router_ingress
   import router_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 3,
   parameter int unsigned DW        = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 pkt_valid,
   input  logic [DW-1:0]        data_in,
   input  logic [NUM_PORTS-1:0] fifo_full,
   output logic                 busy,
   output logic [NUM_PORTS-1:0] wr_en,
   output logic [DW-1:0]        dout,
   output logic                 lfd,
   output logic                 err,
   output logic                 parity_done
);

   state_t              state;
   logic                hold_valid;
   logic                hdr_flag;
   logic                err_pend;
   logic [ADDR_W-1:0]   dest;
   logic [DW-1:0]       par_acc;
   logic                full_sel;
   logic                accept;
   logic                wr_any;
   logic                load;
   logic                dest_ok;

   always_comb begin
      full_sel = 1'b0;
      wr_en    = '0;
      // dest may name a nonexistent port while dropping; such a dest matches nothing
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (dest == ADDR_W'(i)) begin
            full_sel = fifo_full[i];
            wr_en[i] = hold_valid & ~fifo_full[i];
         end
      end
      wr_any  = |wr_en;
      busy    = (state == FLUSH) | (hold_valid & full_sel);
      accept  = pkt_valid & ~busy;
      lfd     = wr_any & hdr_flag;
      dest_ok = 32'(hdr_addr(data_in)) < NUM_PORTS;
      load    = accept & (((state == IDLE) & dest_ok) |
                          (state == PAYLOAD) | (state == PARITY));
   end

   router_ingress_fsm #(
      .NUM_PORTS(NUM_PORTS)
   ) u_fsm (
      .clk         (clk),
      .rstn        (rstn),
      .accept      (accept),
      .data_in     (data_in),
      .wr_any      (wr_any),
      .state       (state),
      .parity_done (parity_done)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_valid <= 1'b0;
         hdr_flag   <= 1'b0;
         dout       <= '0;
         dest       <= '0;
         par_acc    <= '0;
         err_pend   <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (load) begin
            dout       <= data_in;
            hold_valid <= 1'b1;
         end else if (wr_any) begin
            hold_valid <= 1'b0;
         end

         if (load && state == IDLE)
            hdr_flag <= 1'b1;
         else if (wr_any)
            hdr_flag <= 1'b0;

         if (accept && state == IDLE) begin
            dest    <= hdr_addr(data_in);
            par_acc <= data_in;
            err     <= 1'b0;
         end

         if (accept && state == PAYLOAD)
            par_acc <= par_acc ^ data_in;

         if (accept && state == PARITY)
            err_pend <= (data_in != par_acc);

         if (state == FLUSH && wr_any)
            err <= err_pend;
      end
   end

endmodule

// File: tb/tb_router_ingress.sv
// Scoreboard bench for router_ingress: stimulus pushes expected writes and
// completions; a negedge monitor pops and compares them.
module tb_router_ingress;

   logic       clk;
   logic       rstn;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [2:0] fifo_full;
   logic       busy;
   logic [2:0] wr_en;
   logic [7:0] dout;
   logic       lfd;
   logic       err;
   logic       parity_done;

   typedef struct {
      logic [2:0] wr;
      logic [7:0] d;
      logic       lfd;
   } wexp_t;

   wexp_t wq[$];
   logic  dq[$];

   int n_checks = 0;
   int n_fail   = 0;

   router_ingress #(
      .NUM_PORTS(3),
      .DW(8)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .pkt_valid   (pkt_valid),
      .data_in     (data_in),
      .fifo_full   (fifo_full),
      .busy        (busy),
      .wr_en       (wr_en),
      .dout        (dout),
      .lfd         (lfd),
      .err         (err),
      .parity_done (parity_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_wr(input logic [2:0] wr, input logic [7:0] d, input logic l);
      wexp_t e;
      e.wr  = wr;
      e.d   = d;
      e.lfd = l;
      wq.push_back(e);
   endtask

   // monitor: sampled mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (rstn) begin
         if (wr_en != 3'b000) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", {29'd0, wr_en}, 32'd0);
            end else begin
               wexp_t e;
               e = wq.pop_front();
               chk("wr_en", {29'd0, wr_en}, {29'd0, e.wr});
               chk("dout", {24'd0, dout}, {24'd0, e.d});
               chk("lfd", {31'd0, lfd}, {31'd0, e.lfd});
            end
         end else if (lfd) begin
            chk("lfd_without_write", {31'd0, lfd}, 32'd0);
         end
         if (parity_done) begin
            if (dq.size() == 0) begin
               chk("unexpected_parity_done", {31'd0, parity_done}, 32'd0);
            end else begin
               logic e_err;
               e_err = dq.pop_front();
               chk("err_at_done", {31'd0, err}, {31'd0, e_err});
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output int waits);
      pkt_valid = 1'b1;
      data_in   = b;
      waits     = 0;
      forever begin
         @(negedge clk);
         if (!busy) break;
         waits++;
         if (waits > 50) begin
            chk("accept_timeout", 32'd1, 32'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      pkt_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_wr_en"}, {29'd0, wr_en}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_lfd"}, {31'd0, lfd}, 32'd0);
      chk({tag, "_parity_done"}, {31'd0, parity_done}, 32'd0);
      chk({tag, "_dout"}, {24'd0, dout}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
   endtask

   initial begin
      int w;
      int wsum;
      rstn      = 1'b0;
      pkt_valid = 1'b0;
      data_in   = 8'h00;
      fifo_full = 3'b000;
      #12;
      check_all_zero("reset");
      @(posedge clk);
      #1 rstn = 1'b1;
      idle_cycles(2);

      // reset mid-packet: header written, payload 11 held, then reset
      push_wr(3'b010, 8'h09, 1'b1);
      send_byte(8'h09, w);
      send_byte(8'h11, w);
      pkt_valid = 1'b0;
      chk("pre_reset_hold_write", {29'd0, wr_en}, 32'h2);
      rstn = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      idle_cycles(2);

      // port 1, LEN=2, good parity, full throughput
      push_wr(3'b010, 8'h09, 1'b1);
      push_wr(3'b010, 8'h11, 1'b0);
      push_wr(3'b010, 8'h22, 1'b0);
      push_wr(3'b010, 8'h3A, 1'b0);
      dq.push_back(1'b0);
      wsum = 0;
      send_byte(8'h09, w); wsum += w;
      send_byte(8'h11, w); wsum += w;
      send_byte(8'h22, w); wsum += w;
      send_byte(8'h3A, w); wsum += w;
      chk("t2_no_stall", wsum, 32'd0);
      idle_cycles(4);

      // same packet, bad parity
      push_wr(3'b010, 8'h09, 1'b1);
      push_wr(3'b010, 8'h11, 1'b0);
      push_wr(3'b010, 8'h22, 1'b0);
      push_wr(3'b010, 8'h3B, 1'b0);
      dq.push_back(1'b1);
      send_byte(8'h09, w);
      send_byte(8'h11, w);
      send_byte(8'h22, w);
      send_byte(8'h3B, w);
      idle_cycles(4);
      chk("t3_err_held", {31'd0, err}, 32'd1);

      // back-pressure on port 1 after payload 11 is accepted
      push_wr(3'b010, 8'h09, 1'b1);
      push_wr(3'b010, 8'h11, 1'b0);
      push_wr(3'b010, 8'h22, 1'b0);
      push_wr(3'b010, 8'h3A, 1'b0);
      dq.push_back(1'b0);
      send_byte(8'h09, w);
      chk("t4_err_cleared_by_header", {31'd0, err}, 32'd0);
      send_byte(8'h11, w);
      fifo_full = 3'b010;
      data_in   = 8'h22;
      pkt_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_busy_while_full", {31'd0, busy}, 32'd1);
         chk("t4_no_write_while_full", {29'd0, wr_en}, 32'd0);
         @(posedge clk);
         #1;
      end
      fifo_full = 3'b000;
      send_byte(8'h22, w);
      send_byte(8'h3A, w);
      idle_cycles(4);

      // invalid address 3, LEN=2: dropped
      dq.push_back(1'b0);
      wsum = 0;
      send_byte(8'h0B, w); wsum += w;
      send_byte(8'hAA, w); wsum += w;
      send_byte(8'hBB, w); wsum += w;
      send_byte(8'h5C, w); wsum += w;
      chk("t5_never_busy", wsum, 32'd0);
      idle_cycles(3);
      chk("t5_err_zero", {31'd0, err}, 32'd0);

      // port 2, LEN=0, then back-to-back packets to ports 1 and 0
      push_wr(3'b100, 8'h02, 1'b1);
      push_wr(3'b100, 8'h02, 1'b0);
      dq.push_back(1'b0);
      push_wr(3'b010, 8'h05, 1'b1);
      push_wr(3'b010, 8'h77, 1'b0);
      push_wr(3'b010, 8'h72, 1'b0);
      dq.push_back(1'b0);
      push_wr(3'b001, 8'h04, 1'b1);
      push_wr(3'b001, 8'h5A, 1'b0);
      push_wr(3'b001, 8'h5E, 1'b0);
      dq.push_back(1'b0);
      send_byte(8'h02, w);
      send_byte(8'h02, w);
      send_byte(8'h05, w);
      chk("t6_header_after_flush_wait", w, 32'd1);
      send_byte(8'h77, w);
      send_byte(8'h72, w);
      send_byte(8'h04, w);
      chk("t6_second_b2b_wait", w, 32'd1);
      send_byte(8'h5A, w);
      send_byte(8'h5E, w);
      pkt_valid = 1'b0;

      for (int i = 0; i < 50; i++) begin
         if (wq.size() == 0 && dq.size() == 0) break;
         @(posedge clk);
      end
      idle_cycles(3);
      chk("writes_drained", wq.size(), 32'd0);
      chk("dones_drained", dq.size(), 32'd0);
      chk("final_err", {31'd0, err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
